// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: num_pulses pulses of high_len cycles high / low_len cycles low.
// Latency: accepted start -> first output change one cycle later; every output is a flop.
// Backpressure: none; start is honoured only in IDLE and ignored while busy or in DONE.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   start           : request pulse, sampled only in IDLE (suppressed by a simultaneous abort)
//   high_len        : high-phase length in cycles (0 behaves as 1), captured on accepted start
//   low_len         : low-phase length in cycles (0 behaves as 1), captured on accepted start
//   num_pulses      : pulses per request (0 gives an immediate done), captured on accepted start
//   abort           : ends an active train at once; data_out drops, no done
//   data_out        : generated waveform
//   rise_strobe     : one-cycle flag on the first high cycle after a low cycle
//   fall_strobe     : one-cycle flag on the first low cycle after a high cycle
//   busy            : high for every HIGH/LOW cycle of a train
//   done            : one-cycle completion pulse, the cycle after the last busy cycle
module pulse_train_gen #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic             abort,
  output logic             data_out,
  output logic             rise_strobe,
  output logic             fall_strobe,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Phase counter holds "cycles left in this phase minus one", so a phase ends
  // when it reads zero. Storing length-1 lets the full 2^CNT_W-1 length fit
  // and makes a zero length collapse naturally onto a one-cycle phase.
  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] w_phase_nxt;

  // Pulses still to be emitted, including the one in flight.
  logic [NUM_W-1:0] r_pulse_cnt;
  logic [NUM_W-1:0] w_pulse_nxt;

  // Captured reload values (length-1, clamped at 0).
  logic [CNT_W-1:0] r_high_rld;
  logic [CNT_W-1:0] r_low_rld;
  logic [CNT_W-1:0] w_high_rld_in;
  logic [CNT_W-1:0] w_low_rld_in;
  logic             w_capture;

  // Registered outputs and their next values.
  logic r_data_out;
  logic r_rise;
  logic r_fall;
  logic r_busy;
  logic r_done;
  logic w_data_nxt;
  logic w_rise_nxt;
  logic w_fall_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  // max(len,1)-1 computed straight from the inputs, used on the capture edge.
  assign w_high_rld_in = (high_len == '0) ? '0 : (high_len - CNT_W'(1));
  assign w_low_rld_in  = (low_len  == '0) ? '0 : (low_len  - CNT_W'(1));

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase_cnt;
    w_pulse_nxt = r_pulse_cnt;
    w_capture   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        w_pulse_nxt = '0;
        if (start && !abort) begin
          w_capture = 1'b1;
          if (num_pulses == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_HIGH;
            // The reload registers are loaded on this same edge, so the
            // first phase length comes straight from the input.
            w_phase_nxt = w_high_rld_in;
            w_pulse_nxt = num_pulses;
          end
        end
      end

      S_HIGH: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = '0;
          w_pulse_nxt = '0;
        end else if (r_phase_cnt == '0) begin
          w_state_nxt = S_LOW;
          w_phase_nxt = r_low_rld;
        end else begin
          w_phase_nxt = r_phase_cnt - CNT_W'(1);
        end
      end

      S_LOW: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_phase_nxt = '0;
          w_pulse_nxt = '0;
        end else if (r_phase_cnt == '0) begin
          // A count of one (or less) means the pulse just finished was the last.
          if (r_pulse_cnt <= NUM_W'(1)) begin
            w_state_nxt = S_DONE;
            w_pulse_nxt = '0;
            w_phase_nxt = '0;
          end else begin
            w_state_nxt = S_HIGH;
            w_pulse_nxt = r_pulse_cnt - NUM_W'(1);
            w_phase_nxt = r_high_rld;
          end
        end else begin
          w_phase_nxt = r_phase_cnt - CNT_W'(1);
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here; a new request can only
        // be accepted from IDLE on the following cycle.
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
        w_pulse_nxt = '0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = '0;
        w_pulse_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so every output lands in a flop.
  // Edge strobes compare the next waveform value with the current one, which
  // guarantees rise and fall are mutually exclusive and one cycle wide.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_data_nxt = (w_state_nxt == S_HIGH);
    w_busy_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_LOW);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_rise_nxt = w_data_nxt && !r_data_out;
    w_fall_nxt = !w_data_nxt && r_data_out;
  end

  // ---------------------------------------------------------------------------
  // State, counters, captured parameters and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= '0;
      r_pulse_cnt <= '0;
      r_high_rld  <= '0;
      r_low_rld   <= '0;
      r_data_out  <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase_cnt <= w_phase_nxt;
      r_pulse_cnt <= w_pulse_nxt;
      if (w_capture) begin
        r_high_rld <= w_high_rld_in;
        r_low_rld  <= w_low_rld_in;
      end
      r_data_out  <= w_data_nxt;
      r_rise      <= w_rise_nxt;
      r_fall      <= w_fall_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign data_out    = r_data_out;
  assign rise_strobe = r_rise;
  assign fall_strobe = r_fall;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen.
// Outputs are observed 1 time unit after each rising edge; observation k after
// the start-sampling edge T is the cycle "T+k".
module tb_pulse_train_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] num_pulses;
  logic       abort;
  logic       data_out;
  logic       rise_strobe;
  logic       fall_strobe;
  logic       busy;
  logic       done;

  // {data_out, rise_strobe, fall_strobe, busy, done}
  logic [4:0] obs;
  assign obs = {data_out, rise_strobe, fall_strobe, busy, done};

  int checks = 0;
  int errors = 0;

  pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .high_len    (high_len),
    .low_len     (low_len),
    .num_pulses  (num_pulses),
    .abort       (abort),
    .data_out    (data_out),
    .rise_strobe (rise_strobe),
    .fall_strobe (fall_strobe),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held with start=1: nothing may start, all outputs stay low.
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    high_len = 8'd3; low_len = 8'd2; num_pulses = 8'd4;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", i, obs, 5'b00000);
      end
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got %b want %b", i, obs, 5'b00000);
      end
    end
  endtask

  // h=3, l=2, n=4: 1,1,1,0,0 x4, done at T+21.
  task automatic test_basic();
    int hh, ll, n, p, pos;
    logic [4:0] exp;
    hh = 3; ll = 2; n = 4; p = hh + ll;
    high_len = 8'd3; low_len = 8'd2; num_pulses = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= n * p + 2; k++) begin
      pos = (k - 1) % p;
      if (k <= n * p)          exp = {pos < hh, pos == 0, pos == hh, 1'b1, 1'b0};
      else if (k == n * p + 1) exp = 5'b00001;
      else                     exp = 5'b00000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic T+%0d: got %b want %b", k, obs, exp);
      end
      tick();
    end
  endtask

  // Zero lengths behave as 1; zero count gives an immediate done.
  task automatic test_zero_len();
    int n, pos;
    logic [4:0] exp;
    n = 3;
    high_len = 8'd0; low_len = 8'd0; num_pulses = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      pos = (k - 1) % 2;
      if (k <= 2 * n)      exp = {pos == 0, pos == 0, pos == 1, 1'b1, 1'b0};
      else if (k == 7)     exp = 5'b00001;
      else                 exp = 5'b00000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL zero_len T+%0d: got %b want %b", k, obs, exp);
      end
      tick();
    end

    high_len = 8'd4; low_len = 8'd4; num_pulses = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp = (k == 1) ? 5'b00001 : 5'b00000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL zero_count T+%0d: got %b want %b", k, obs, exp);
      end
      tick();
    end
  endtask

  // Abort in HIGH, in LOW, and a start suppressed by abort in IDLE.
  task automatic test_abort();
    int hh, ll, n, p, pos;
    logic [4:0] exp;
    high_len = 8'd5; low_len = 8'd5; num_pulses = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs !== 5'b11010) begin
      errors++;
      $display("FAIL abort_high_t1: got %b want %b", obs, 5'b11010);
    end
    tick();
    tick();
    checks++;
    if (obs !== 5'b10010) begin
      errors++;
      $display("FAIL abort_high_t3: got %b want %b", obs, 5'b10010);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (obs !== 5'b00100) begin
      errors++;
      $display("FAIL abort_high_next: got %b want %b", obs, 5'b00100);
    end
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL abort_high_after: got %b want %b", obs, 5'b00000);
    end

    // Fresh full train after the abort.
    hh = 5; ll = 5; n = 2; p = hh + ll;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= n * p + 2; k++) begin
      pos = (k - 1) % p;
      if (k <= n * p)          exp = {pos < hh, pos == 0, pos == hh, 1'b1, 1'b0};
      else if (k == n * p + 1) exp = 5'b00001;
      else                     exp = 5'b00000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL abort_restart T+%0d: got %b want %b", k, obs, exp);
      end
      tick();
    end

    // Abort in LOW: no fall strobe since the line is already low.
    high_len = 8'd1; low_len = 8'd3; num_pulses = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b00110) begin
      errors++;
      $display("FAIL abort_low_t2: got %b want %b", obs, 5'b00110);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL abort_low_next: got %b want %b", obs, 5'b00000);
    end
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL abort_low_no_done: got %b want %b", obs, 5'b00000);
    end

    // Abort in IDLE suppresses a simultaneous start.
    high_len = 8'd2; low_len = 8'd2; num_pulses = 8'd2;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL abort_idle T+%0d: got %b want %b", k, obs, 5'b00000);
      end
      tick();
    end
  endtask

  // start held every cycle with other parameters: original waveform, one done.
  task automatic test_ignored_start();
    int hh, ll, n, p, pos, done_cnt;
    logic [4:0] exp;
    hh = 2; ll = 3; n = 3; p = hh + ll; done_cnt = 0;
    high_len = 8'd2; low_len = 8'd3; num_pulses = 8'd3;
    start = 1'b1;
    tick();
    high_len = 8'd7; low_len = 8'd1; num_pulses = 8'd9;
    for (int k = 1; k <= n * p + 2; k++) begin
      pos = (k - 1) % p;
      if (k <= n * p)          exp = {pos < hh, pos == 0, pos == hh, 1'b1, 1'b0};
      else if (k == n * p + 1) exp = 5'b00001;
      else                     exp = 5'b00000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ignored_start T+%0d: got %b want %b", k, obs, exp);
      end
      if (done === 1'b1) done_cnt++;
      start = (k <= n * p + 1);
      tick();
    end
    start = 1'b0;
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL ignored_start_done_count: got %0d want %0d", done_cnt, 1);
    end
  endtask

  // Start in DONE is ignored; start in the following IDLE cycle is accepted.
  task automatic test_back_to_back();
    logic [4:0] exp_v [0:10];
    exp_v[0]  = 5'b11010; exp_v[1] = 5'b00110; exp_v[2] = 5'b11010;
    exp_v[3]  = 5'b00110; exp_v[4] = 5'b00001; exp_v[5] = 5'b00000;
    exp_v[6]  = 5'b11010; exp_v[7] = 5'b10010; exp_v[8] = 5'b00110;
    exp_v[9]  = 5'b00001; exp_v[10] = 5'b00000;
    high_len = 8'd1; low_len = 8'd1; num_pulses = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      checks++;
      if (obs !== exp_v[k-1]) begin
        errors++;
        $display("FAIL back_to_back T+%0d: got %b want %b", k, obs, exp_v[k-1]);
      end
      if (k >= 4 && k <= 6) begin
        start = 1'b1;
        high_len = 8'd2; low_len = 8'd1; num_pulses = 8'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  // Reset in the middle of a train: all low at once, no fall, no done.
  task automatic test_reset_mid();
    high_len = 8'd4; low_len = 8'd4; num_pulses = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b10010) begin
      errors++;
      $display("FAIL reset_mid_pre: got %b want %b", obs, 5'b10010);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset_mid cycle %0d: got %b want %b", k, obs, 5'b00000);
      end
      tick();
    end
  endtask

  // 255 high, 255 low, done at T+511, exactly one rise and one fall.
  task automatic test_max_len();
    int hh, ll, n, p, pos, rise_cnt, fall_cnt;
    logic [4:0] exp;
    hh = 255; ll = 255; n = 1; p = hh + ll; rise_cnt = 0; fall_cnt = 0;
    high_len = 8'd255; low_len = 8'd255; num_pulses = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= n * p + 2; k++) begin
      pos = (k - 1) % p;
      if (k <= n * p)          exp = {pos < hh, pos == 0, pos == hh, 1'b1, 1'b0};
      else if (k == n * p + 1) exp = 5'b00001;
      else                     exp = 5'b00000;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL max_len T+%0d: got %b want %b", k, obs, exp);
      end
      if (rise_strobe === 1'b1) rise_cnt++;
      if (fall_strobe === 1'b1) fall_cnt++;
      tick();
    end
    checks++;
    if (rise_cnt !== 1 || fall_cnt !== 1) begin
      errors++;
      $display("FAIL max_len_edges: got rise=%0d fall=%0d want rise=1 fall=1", rise_cnt, fall_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    high_len = 8'd0; low_len = 8'd0; num_pulses = 8'd0;
    test_reset();
    test_basic();
    test_zero_len();
    test_abort();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
